// File: rtl/cnn_pkg.sv
// Shared types and dimensions for the CNN pooling stage.
// Holds the control FSM encoding, map sizes and requantization limits.
package cnn_pkg;

  localparam int NUM_FILT = 16;
  localparam int CONV_DIM = 26;
  localparam int POOL_DIM = 13;

  localparam int IDX_W = 4;

  localparam logic [IDX_W-1:0] LAST_FILT = IDX_W'(NUM_FILT - 1);
  localparam logic [IDX_W-1:0] LAST_POOL = IDX_W'(POOL_DIM - 1);

  // Requantized outputs are int8.
  localparam logic signed [31:0] SAT_MAX = 32'sd127;
  localparam logic signed [31:0] SAT_MIN = -32'sd128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pool_unit.sv
// 2x2 max-pool of one window followed by arithmetic shift and int8 saturation.
// Purely combinational; the top steps it across all window positions.
module pool_unit
  import cnn_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic signed [31:0] i_a,
  input  logic signed [31:0] i_b,
  input  logic signed [31:0] i_c,
  input  logic signed [31:0] i_d,
  output logic signed [7:0]  o_q
);

  logic signed [31:0] w_max_ab;
  logic signed [31:0] w_max_cd;
  logic signed [31:0] w_max;
  logic signed [31:0] w_shifted;

  // All operands are signed, so the comparisons are signed.
  assign w_max_ab  = (i_a > i_b) ? i_a : i_b;
  assign w_max_cd  = (i_c > i_d) ? i_c : i_d;
  assign w_max     = (w_max_ab > w_max_cd) ? w_max_ab : w_max_cd;
  assign w_shifted = w_max >>> SHIFT;

  always_comb begin
    o_q = w_shifted[7:0];
    if (w_shifted > SAT_MAX) begin
      o_q = 8'sd127;
    end else if (w_shifted < SAT_MIN) begin
      o_q = -8'sd128;
    end
  end

endmodule

// File: rtl/maxpool_requant.sv
// Sequential 2x2/stride-2 max-pool with requantization of a 16x26x26 conv map.
// One pooled entry is produced per clock in RUN, reusing a single pool_unit.
module maxpool_requant
  import cnn_pkg::*;
#(
  parameter int SHIFT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [31:0] feature_map [NUM_FILT][CONV_DIM][CONV_DIM],
  input  logic               t,
  output logic               d,
  output logic signed [7:0]  pool_map [NUM_FILT][POOL_DIM][POOL_DIM],
  output state_t             o_state
);

  // Start/done protocol: t is sampled only in IDLE and launches one full pass;
  // feature_map must stay stable until d, a single-cycle pulse emitted as the
  // final entry is written. t in RUN/DONE is ignored.

  state_t                 r_state;
  state_t                 w_state_next;
  logic [IDX_W-1:0]       r_f;
  logic [IDX_W-1:0]       r_i;
  logic [IDX_W-1:0]       r_j;
  logic                   r_d;
  logic                   w_write;
  logic                   w_last_f;
  logic                   w_last_i;
  logic                   w_last_j;
  logic                   w_last;
  logic [IDX_W:0]         w_row0;
  logic [IDX_W:0]         w_row1;
  logic [IDX_W:0]         w_col0;
  logic [IDX_W:0]         w_col1;
  logic signed [7:0]      w_pooled;

  assign w_last_f = (r_f == LAST_FILT);
  assign w_last_i = (r_i == LAST_POOL);
  assign w_last_j = (r_j == LAST_POOL);
  assign w_last   = w_last_f && w_last_i && w_last_j;

  // Window origin is (2i, 2j); appending the row/col offset bit avoids a multiply.
  assign w_row0 = {r_i, 1'b0};
  assign w_row1 = {r_i, 1'b1};
  assign w_col0 = {r_j, 1'b0};
  assign w_col1 = {r_j, 1'b1};

  pool_unit #(
    .SHIFT(SHIFT)
  ) u_pool_unit (
    .i_a(feature_map[r_f][w_row0][w_col0]),
    .i_b(feature_map[r_f][w_row0][w_col1]),
    .i_c(feature_map[r_f][w_row1][w_col0]),
    .i_d(feature_map[r_f][w_row1][w_col1]),
    .o_q(w_pooled)
  );

  always_comb begin
    w_state_next = r_state;
    w_write      = 1'b0;
    case (r_state)
      IDLE: begin
        if (t) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_write = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_f     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_d     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_d     <= w_write && w_last;
      if (w_write) begin
        if (w_last) begin
          r_f <= '0;
          r_i <= '0;
          r_j <= '0;
        end else if (w_last_j) begin
          r_j <= '0;
          if (w_last_i) begin
            r_i <= '0;
            if (!w_last_f) begin
              r_f <= r_f + 1'b1;
            end
          end else begin
            r_i <= r_i + 1'b1;
          end
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
    end
  end

  // Result storage is deliberately not reset so a reset keeps prior results.
  always_ff @(posedge clk) begin
    if (w_write) begin
      pool_map[r_f][r_i][r_j] <= w_pooled;
    end
  end

  assign d       = r_d;
  assign o_state = r_state;

endmodule
